// File: rtl/cpu_pkg.sv
`timescale 1ps/1ps
// Shared CPU definitions: opcode slots, fetch sequencer states and the
// instruction-size constant used by the fetch PC incrementer.
package cpu_pkg;

  localparam logic [3:0] OP_PC_INIT = 4'd0;
  localparam logic [3:0] OP_ADDI    = 4'd1;
  localparam logic [3:0] OP_ADDS    = 4'd2;
  localparam logic [3:0] OP_BLT     = 4'd3;
  localparam logic [3:0] OP_B       = 4'd4;
  localparam logic [3:0] OP_CBZ     = 4'd5;
  localparam logic [3:0] OP_LDUR    = 4'd6;
  localparam logic [3:0] OP_LSL     = 4'd7;
  localparam logic [3:0] OP_LSR     = 4'd8;
  localparam logic [3:0] OP_MUL     = 4'd9;
  localparam logic [3:0] OP_STUR    = 4'd10;
  localparam logic [3:0] OP_SUBS    = 4'd11;
  localparam logic [3:0] OP_INV     = 4'd12;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } fetch_state_t;

  // Sequential fetch address; wraps silently at 2^64.
  function automatic logic [63:0] pc_inc(input logic [63:0] pc);
    return pc + 64'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
`timescale 1ps/1ps
// Link between fetch and the ID-stage branch unit: ID drives stall and the
// branch decision, fetch returns the IF/ID register contents.
interface fetch_pc_ctrl_if;

  logic        stall;
  logic        BrTaken;
  logic [63:0] pc_br;
  logic [63:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;
  logic        ds_out;

  modport master (
    input  stall,
    input  BrTaken,
    input  pc_br,
    output pc_out,
    output instr_out,
    output valid_out,
    output ds_out
  );

  modport slave (
    output stall,
    output BrTaken,
    output pc_br,
    input  pc_out,
    input  instr_out,
    input  valid_out,
    input  ds_out
  );

endinterface

// File: rtl/fetch_pc_ctrl_if_id_reg.sv
`timescale 1ps/1ps
// Enable-gated IF/ID pipeline register holding {pc, instr, valid, ds}.
module if_id_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [63:0] pc_d,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic        ds_d,
  output logic [63:0] pc_q,
  output logic [31:0] instr_q,
  output logic        valid_q,
  output logic        ds_q
);

  // IF/ID storage: cleared in reset, loaded only when fetch advances
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= 64'h0;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      ds_q    <= 1'b0;
    end else if (en) begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      ds_q    <= ds_d;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
`timescale 1ps/1ps
// Fetch-side PC controller: owns the fetch PC, the IF/ID register and
// one-instruction delay-slot sequencing, deferring redirects across stalls.
module fetch_pc_ctrl
  import cpu_pkg::*;
#(
  parameter logic [63:0] PC_INIT = 64'h0,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  fetch_pc_ctrl_if.master  id,
  input  logic [31:0]      instr_in,
  output logic [63:0]      pc_if,
  output logic             redirect,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  fetch_state_t     state_r;
  fetch_state_t     state_nxt_s;
  logic [63:0]      pc_if_r;
  logic [63:0]      pend_tgt_r;
  logic             redirect_r;
  logic [CNT_W-1:0] br_cnt_r;
  logic [CNT_W-1:0] inst_cnt_r;

  logic             br_q_s;
  logic             ifid_en_s;
  logic             ifid_ds_s;
  logic             pc_ld_s;
  logic [63:0]      pc_nxt_s;
  logic             pend_ld_s;
  logic             redirect_nxt_s;
  logic             br_inc_s;
  logic             inst_inc_s;

  // A branch decision only counts when ID holds a real instruction.
  assign br_q_s = id.BrTaken & id.valid_out;

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: a taken branch under stall parks in PEND until release
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BOOT: state_nxt_s = RUN;
      RUN: begin
        if (id.stall && br_q_s) begin
          state_nxt_s = PEND;
        end else begin
          state_nxt_s = RUN;
        end
      end
      PEND: begin
        if (!id.stall) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = PEND;
        end
      end
      default: state_nxt_s = BOOT;
    endcase
  end

  // Datapath controls per state
  always_comb begin
    ifid_en_s      = 1'b0;
    ifid_ds_s      = 1'b0;
    pc_ld_s        = 1'b0;
    pc_nxt_s       = pc_if_r;
    pend_ld_s      = 1'b0;
    redirect_nxt_s = 1'b0;
    br_inc_s       = 1'b0;
    inst_inc_s     = 1'b0;
    case (state_r)
      BOOT: begin
        ifid_en_s  = 1'b1;
        pc_ld_s    = 1'b1;
        pc_nxt_s   = pc_inc(pc_if_r);
        inst_inc_s = 1'b1;
      end
      RUN: begin
        if (!id.stall) begin
          ifid_en_s      = 1'b1;
          ifid_ds_s      = br_q_s;
          pc_ld_s        = 1'b1;
          pc_nxt_s       = br_q_s ? id.pc_br : pc_inc(pc_if_r);
          redirect_nxt_s = br_q_s;
          br_inc_s       = br_q_s;
          inst_inc_s     = 1'b1;
        end else begin
          pend_ld_s = br_q_s;
          br_inc_s  = br_q_s;
        end
      end
      PEND: begin
        // The branch was already counted when it was parked.
        if (!id.stall) begin
          ifid_en_s      = 1'b1;
          ifid_ds_s      = 1'b1;
          pc_ld_s        = 1'b1;
          pc_nxt_s       = pend_tgt_r;
          redirect_nxt_s = 1'b1;
          inst_inc_s     = 1'b1;
        end else begin
          ifid_en_s = 1'b0;
        end
      end
      default: begin
        ifid_en_s = 1'b0;
      end
    endcase
  end

  // Fetch PC, parked target, redirect pulse and performance counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_if_r    <= PC_INIT;
      pend_tgt_r <= 64'h0;
      redirect_r <= 1'b0;
      br_cnt_r   <= {CNT_W{1'b0}};
      inst_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (pc_ld_s) begin
        pc_if_r <= pc_nxt_s;
      end
      if (pend_ld_s) begin
        pend_tgt_r <= id.pc_br;
      end
      redirect_r <= redirect_nxt_s;
      br_cnt_r   <= br_cnt_r + {{(CNT_W-1){1'b0}}, br_inc_s};
      inst_cnt_r <= inst_cnt_r + {{(CNT_W-1){1'b0}}, inst_inc_s};
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .en      (ifid_en_s),
    .pc_d    (pc_if_r),
    .instr_d (instr_in),
    .valid_d (1'b1),
    .ds_d    (ifid_ds_s),
    .pc_q    (id.pc_out),
    .instr_q (id.instr_out),
    .valid_q (id.valid_out),
    .ds_q    (id.ds_out)
  );

  assign pc_if    = pc_if_r;
  assign redirect = redirect_r;
  assign br_cnt   = br_cnt_r;
  assign inst_cnt = inst_cnt_r;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
`timescale 1ps/1ps
// Bench for fetch_pc_ctrl: directed scenarios followed by random stall/branch
// traffic, all checked against a cycle-level model of the fetch rules.
module tb_fetch_pc_ctrl;
  import cpu_pkg::*;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   instr_in;
  logic [63:0]   pc_if;
  logic          redirect;
  logic [CW-1:0] br_cnt;
  logic [CW-1:0] inst_cnt;

  fetch_pc_ctrl_if id_if ();

  fetch_pc_ctrl #(.PC_INIT(64'h0), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .id       (id_if.master),
    .instr_in (instr_in),
    .pc_if    (pc_if),
    .redirect (redirect),
    .br_cnt   (br_cnt),
    .inst_cnt (inst_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model of architectural fetch state.
  logic [63:0]   m_pc_if, m_pc_out, m_tgt;
  logic [31:0]   m_instr;
  logic          m_valid, m_ds, m_redir, m_booted, m_pend;
  logic [CW-1:0] m_br, m_inst;

  function automatic logic [31:0] imem(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    fetch_state_t es;
    es = !m_booted ? BOOT : (m_pend ? PEND : RUN);
    chk("pc_if", pc_if, m_pc_if);
    chk("pc_out", id_if.pc_out, m_pc_out);
    chk("instr_out", 64'(id_if.instr_out), 64'(m_instr));
    chk("valid_out", 64'(id_if.valid_out), 64'(m_valid));
    chk("ds_out", 64'(id_if.ds_out), 64'(m_ds));
    chk("redirect", 64'(redirect), 64'(m_redir));
    chk("br_cnt", 64'(br_cnt), 64'(m_br));
    chk("inst_cnt", 64'(inst_cnt), 64'(m_inst));
    chk("state", 64'(dut.state_r), 64'(es));
    chk("pend_tgt", dut.pend_tgt_r, m_tgt);
  endtask

  task automatic model_step(input logic rst_v, input logic st, input logic bt,
                            input logic [63:0] br, input logic [31:0] ins);
    logic brq;
    if (!rst_v) begin
      m_pc_if = 64'h0; m_pc_out = 64'h0; m_instr = 32'h0; m_valid = 1'b0;
      m_ds = 1'b0; m_redir = 1'b0; m_br = '0; m_inst = '0;
      m_booted = 1'b0; m_pend = 1'b0; m_tgt = 64'h0;
    end else if (!m_booted) begin
      m_pc_out = m_pc_if; m_instr = ins; m_valid = 1'b1; m_ds = 1'b0;
      m_pc_if = m_pc_if + 64'd4; m_inst = m_inst + 1'b1;
      m_redir = 1'b0; m_booted = 1'b1;
    end else begin
      brq = bt & m_valid;
      if (m_pend) begin
        if (!st) begin
          m_pc_out = m_pc_if; m_instr = ins; m_valid = 1'b1; m_ds = 1'b1;
          m_pc_if = m_tgt; m_redir = 1'b1; m_inst = m_inst + 1'b1;
          m_pend = 1'b0;
        end else begin
          m_redir = 1'b0;
        end
      end else if (!st) begin
        m_pc_out = m_pc_if; m_instr = ins; m_valid = 1'b1; m_ds = brq;
        m_pc_if = brq ? br : m_pc_if + 64'd4;
        m_redir = brq; m_br = m_br + CW'(brq); m_inst = m_inst + 1'b1;
      end else begin
        m_redir = 1'b0;
        if (brq) begin
          m_tgt = br; m_br = m_br + 1'b1; m_pend = 1'b1;
        end else begin
          m_pend = 1'b0;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic cycle(input logic rst_v, input logic st, input logic bt, input logic [63:0] br);
    logic [31:0] ins;
    ins = imem(m_pc_if);
    reset = rst_v; id_if.stall = st; id_if.BrTaken = bt; id_if.pc_br = br; instr_in = ins;
    model_step(rst_v, st, bt, br, ins);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic restart_to_pc8();
    cycle(1'b0, 1'b0, 1'b0, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    m_pc_if = 64'h0; m_booted = 1'b0; m_pend = 1'b0;
    reset = 1'b0; id_if.stall = 1'b0; id_if.BrTaken = 1'b0;
    id_if.pc_br = 64'h0; instr_in = 32'h0;

    // Reset with BrTaken asserted, then boot with BrTaken still high.
    cycle(1'b0, 1'b0, 1'b1, 64'h500);
    cycle(1'b0, 1'b1, 1'b1, 64'h500);
    chk("rst_pc_if", pc_if, 64'h0);
    chk("rst_valid", 64'(id_if.valid_out), 64'h0);
    cycle(1'b1, 1'b1, 1'b1, 64'h500);
    chk("boot_pc_if", pc_if, 64'd4);
    chk("boot_pc_out", id_if.pc_out, 64'h0);
    chk("boot_valid", 64'(id_if.valid_out), 64'h1);

    // Straight line.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 64'h0);
    chk("line_pc_if", pc_if, 64'd20);
    chk("line_inst_cnt", 64'(inst_cnt), 64'd5);

    // Taken branch with pc_out = 8.
    restart_to_pc8();
    chk("pre_br_pc_out", id_if.pc_out, 64'h8);
    cycle(1'b1, 1'b0, 1'b1, 64'h40);
    chk("br_pc_if", pc_if, 64'h40);
    chk("br_pc_out", id_if.pc_out, 64'hC);
    chk("br_ds", 64'(id_if.ds_out), 64'h1);
    chk("br_redirect", 64'(redirect), 64'h1);
    chk("br_cnt1", 64'(br_cnt), 64'h1);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    chk("tgt_pc_out", id_if.pc_out, 64'h40);
    chk("tgt_ds", 64'(id_if.ds_out), 64'h0);

    // Branch under stall; later pc_br values must be ignored.
    restart_to_pc8();
    cycle(1'b1, 1'b1, 1'b1, 64'h80);
    cycle(1'b1, 1'b1, 1'b1, 64'h999);
    cycle(1'b1, 1'b1, 1'b1, 64'h999);
    chk("stall_pc_if", pc_if, 64'hC);
    chk("stall_state", 64'(dut.state_r), 64'(PEND));
    chk("stall_br_cnt", 64'(br_cnt), 64'h1);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    chk("rel_pc_if", pc_if, 64'h80);
    chk("rel_pc_out", id_if.pc_out, 64'hC);
    chk("rel_ds", 64'(id_if.ds_out), 64'h1);
    chk("rel_br_cnt", 64'(br_cnt), 64'h1);

    // Reset while parked in PEND.
    restart_to_pc8();
    cycle(1'b1, 1'b1, 1'b1, 64'h123);
    cycle(1'b0, 1'b1, 1'b1, 64'h0);
    chk("rp_pc_if", pc_if, 64'h0);
    chk("rp_state", 64'(dut.state_r), 64'(BOOT));
    chk("rp_tgt", dut.pend_tgt_r, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    chk("rp_boot_redirect", 64'(redirect), 64'h0);
    chk("rp_boot_pc_out", id_if.pc_out, 64'h0);

    // PC wrap at 2^64 via a target near the top of the address space.
    cycle(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    chk("wrap_pc_if", pc_if, 64'h0);

    // Random traffic; the 8-bit counters wrap many times.
    for (int i = 0; i < 4000; i++) begin
      logic [63:0] br;
      br = {$urandom, $urandom};
      if ($urandom_range(3) == 0) br = 64'(br[9:0]);
      cycle(($urandom_range(149) != 0), ($urandom_range(99) < 30),
            ($urandom_range(99) < 35), br);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
Fetch-side PC controller. It consumes BrTaken and pc_br from the ID-stage accelerated branch unit and drives pc_out back into it. It owns the architectural fetch PC, the IF/ID pipeline register (PC, instruction, valid) and one-instruction delay-slot sequencing. It holds a redirect that arrives during an ID stall and applies it on stall release, and keeps small performance counters.

Parameters:
PC_INIT, 64'h0, fetch address after reset release (matches the PC_INIT opcode slot constant).
delay, 50, gate delay in ps for any structural gates; timescale 1ps/1ps.
CNT_W, 32, width of each performance counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset; 0 = in reset
stall  input  1  ID hazard stall; hold PC and IF/ID
BrTaken  input  1  taken-branch decision from ID this cycle
pc_br  input  64  branch target from ID
instr_in  input  32  instruction-memory read data for pc_if
pc_if  output  64  instruction-memory fetch address
pc_out  output  64  IF/ID PC, fed to the ID branch adder
instr_out  output  32  IF/ID instruction
valid_out  output  1  IF/ID holds a real instruction
ds_out  output  1  instr_out is the delay slot of a taken branch
redirect  output  1  one-cycle pulse when pc_if is loaded with a branch target
br_cnt  output  CNT_W  count of accepted taken branches
inst_cnt  output  CNT_W  count of instructions accepted into IF/ID

Behaviour:
- All state updates on posedge clk; reset is sampled only at the edge.
- Reset (reset==0): pc_if=PC_INIT, pc_out=0, instr_out=0, valid_out=0, ds_out=0, redirect=0, br_cnt=0, inst_cnt=0, pend_tgt=0, state=BOOT. Reset overrides stall and BrTaken and clears PEND mid-operation.
- Qualified branch: br_q = BrTaken & valid_out. BrTaken is ignored when valid_out==0.
- States: BOOT, RUN, PEND.
- BOOT: first edge with reset==1 loads IF/ID from pc_if/instr_in (valid_out=1), sets pc_if=pc_if+4, goes to RUN. stall is ignored in BOOT.
- RUN, stall=0:
  - IF/ID <= {pc_if, instr_in, 1}.
  - pc_if <= br_q ? pc_br : pc_if+4.
  - ds_out <= br_q.
  - redirect <= br_q.
  - br_cnt += br_q.
  - inst_cnt += 1.
- RUN, stall=1, br_q=0: pc_if, IF/ID, ds_out and the counters hold; redirect=0.
- RUN, stall=1, br_q=1: pend_tgt <= pc_br, br_cnt += 1, go to PEND. pc_if and IF/ID hold.
- PEND, stall=1: everything holds. BrTaken and pc_br are ignored; this is the same branch re-evaluated.
- PEND, stall=0: IF/ID <= {pc_if, instr_in, 1} (the delay slot), ds_out=1, pc_if <= pend_tgt, redirect=1, inst_cnt += 1, go to RUN. br_cnt is not re-incremented.
- Delay slot: exactly one instruction (branch PC+4) always executes; nothing is squashed.
  - A branch sitting in a delay slot is processed normally. Its own delay slot is the first target instruction.
- Arithmetic:
  - pc+4 is a 64-bit add; it wraps at 2^64 with no flag.
  - pc_br is used as-is; no alignment check.
  - Counters wrap from all-ones to 0.
- Latency: BrTaken in cycle t gives pc_if=pc_br after edge t (stall=0). Under stall, it is one edge after stall falls.

Decomposition:
- Shared package cpu_pkg holds:
  - the 4-bit opcode constants (PC_INIT=0, ADDI=1, ADDS=2, BLT=3, B=4, CBZ=5, LDUR=6, LSL=7, LSR=8, MUL=9, STUR=10, SUBS=11, INV=12);
  - the fetch_state_t enum {BOOT, RUN, PEND};
  - the INSTR_BYTES=4 constant.
- One sub-module: if_id_reg, the enable-gated IF/ID register holding {pc, instr, valid, ds}. The PC adder reuses the existing 64-bit add module.

Test Plan:
1. Reset: hold reset=0 for 2 cycles -> pc_if=0, valid_out=0, counters=0. First edge with reset=1 -> pc_out=0, valid_out=1, pc_if=4.
2. Straight line: 4 cycles with no stall and no branch -> pc_if 8,12,16,20; inst_cnt=5; ds_out=0 throughout.
3. Taken branch: pc_out=8, BrTaken=1, pc_br=0x40 -> next edge gives pc_if=0x40, pc_out=0xC, ds_out=1, redirect=1, br_cnt=1. The following edge gives pc_out=0x40, ds_out=0.
4. Stall with branch: pc_out=8, stall=1, BrTaken=1, pc_br=0x80 for 3 cycles -> pc_if stays 0xC, state=PEND, br_cnt=1. On stall=0 -> pc_if=0x80, pc_out=0xC, ds_out=1, br_cnt still 1.
5. Reset in PEND: assert reset=0 while in PEND -> pc_if=0, state=BOOT, pend_tgt=0. After release, fetch restarts at 0 with no redirect.
6. Guards: BrTaken=1 while valid_out=0 (BOOT) -> ignored, pc_if=4. Preload br_cnt=0xFFFFFFFF and take a branch -> br_cnt=0.
